// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: 2-flop synchroniser, mid-bit sampling,
// LSB-first shift register, and a one-deep valid/ready output holding register.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              rx_d,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, rx_s_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_d;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d             = '0;
          shift_d           = shift_q >> 1;
          shift_d[DATA_W-1] = rx_s_q;
          idx_d             = idx_q + BW'(1);
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            // Acceptance in this same cycle frees the holding register.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed scenarios then random frames,
// compared against a one-deep mailbox model of the receiver's output side.
module tb_serial_frame_rx;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          rx_d = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, overrun;

  serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .clear(clear), .rx_d(rx_d), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0;
  int err_cnt = 0, ov_cnt = 0, exp_err = 0, exp_ov = 0;
  bit            mb_valid = 1'b0;
  logic [DW-1:0] mb_data = '0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: accepted words, pulse counts, pulse widths and hold behaviour.
  logic          p_clear = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_ferr = 1'b0, p_ovr = 1'b0;
  logic [DW-1:0] p_data = '0;
  always @(negedge clk) begin
    if (clear) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_accept", 32'd1, 32'd0);
        else chk("accept_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (p_ferr) chk("ferr_width", 32'(frame_err), 32'd0);
      if (p_ovr) chk("ovr_width", 32'(overrun), 32'd0);
      if (p_clear && p_valid && !p_ready) begin
        chk("valid_hold", 32'(rx_valid), 32'd1);
        chk("data_hold", 32'(rx_data), 32'(p_data));
      end
      if (rx_valid && !p_valid) rise_cyc <= cyc;
    end
    p_clear <= clear;
    p_valid <= rx_valid;
    p_ready <= rx_ready;
    p_data  <= rx_data;
    p_ferr  <= frame_err;
    p_ovr   <= overrun;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    rx_d = b;
    tick(CPB);
  endtask

  // Sends one frame and updates the model with its expected effect.
  task automatic frame(input logic [DW-1:0] d, input bit stop_ok, input int gap);
    if (!stop_ok) exp_err++;
    else if (rx_ready) exp_q.push_back(d);
    else if (mb_valid) exp_ov++;
    else begin mb_valid = 1'b1; mb_data = d; end
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(stop_ok);
    rx_d = 1'b1;
    tick(gap);
  endtask

  task automatic consume();
    if (mb_valid) begin exp_q.push_back(mb_data); mb_valid = 1'b0; end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("valid_after_ready", 32'(rx_valid), 32'd0);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(mb_valid));
    if (mb_valid) chk({tag, "_data"}, 32'(rx_data), 32'(mb_data));
    chk({tag, "_ferr_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_ovr_cnt"}, 32'(ov_cnt), 32'(exp_ov));
  endtask

  initial begin
    tick(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    clear = 1'b1;
    tick(2);

    // 1: single frame held, then released by ready; latency from start edge
    frame(8'hA5, 1'b1, 6);
    chk("latency", 32'(rise_cyc - start_cyc), 32'(3 + CPB/2 + CPB*(DW+1)));
    checkpoint("t1a");
    tick(5);
    checkpoint("t1b");
    consume();
    checkpoint("t1c");

    // 2: one-clock glitch aborts in START
    rx_d = 1'b0; tick(1); rx_d = 1'b1; tick(20);
    checkpoint("t2");

    // 3: bad stop bit, then recovery
    frame(8'h3C, 1'b0, 6);
    checkpoint("t3a");
    frame(8'h55, 1'b1, 6);
    checkpoint("t3b");
    consume();

    // 4: second word while first still held
    frame(8'h11, 1'b1, 4);
    frame(8'h22, 1'b1, 6);
    checkpoint("t4");

    // 5: reset mid-DATA clears everything at once
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    clear = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rx_valid), 32'd0);
    chk("t5_rst_data", 32'(rx_data), 32'd0);
    chk("t5_rst_ferr", 32'(frame_err), 32'd0);
    chk("t5_rst_ovr", 32'(overrun), 32'd0);
    mb_valid = 1'b0;
    tick(2); rx_d = 1'b1; tick(2);
    clear = 1'b1;
    tick(3);
    frame(8'h0F, 1'b1, 6);
    checkpoint("t5");
    consume();

    // 6: back-to-back frames, consumer always ready
    rx_ready = 1'b1;
    frame(8'h12, 1'b1, 0);
    frame(8'h34, 1'b1, 8);
    rx_ready = 1'b0;
    checkpoint("t6");
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    // Random frames, random stop errors, random consumption
    for (int n = 0; n < 24; n++) begin
      frame(DW'($urandom), ($urandom_range(0, 5) != 0), int'($urandom_range(4, 9)));
      if ($urandom_range(0, 1) == 1) consume();
      checkpoint("rnd");
    end
    consume();
    tick(2);
    chk("pending_words", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
